hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the EX stage and its bypass network. Generates registered bypass
//  selects (forward_a/forward_b), load-use bubbles, branch-mispredict flushes and the global
//  cache-stall freeze (isCacheStall/isFlush). Sits beside ID/EX and takes dest/regwrite info
//  back from EX, MEM and WB.
// PARAMETERS
//  FLUSH_CYCLES  2   consecutive cycles isFlush is held after a mispredict (1..7)
//  CNT_W         32  width of the performance counters
// PORTS
//  clk               in   1      clock
//  rst               in   1      synchronous, active-high reset
//  id_rs, id_rt      in   5 ea   source regs of the instruction in ID
//  id_uses_rs/rt     in   1 ea   ID instruction reads rs / rt
//  ex_write_reg      in   5      EX destination register
//  ex_regwrite_flag  in   1      EX instruction writes a register
//  ex_memread        in   1      EX instruction is a load
//  mem_write_reg     in   5      MEM destination register
//  mem_regwrite_flag in   1      MEM instruction writes a register
//  br_valid          in   1      branch resolved in MEM this cycle
//  br_taken          in   1      actual outcome
//  br_pred           in   2      bht_token carried with that branch (pred taken = bit1)
//  icache_miss       in   1      instruction cache not ready
//  dcache_miss       in   1      data cache not ready
//  forward_a/b       out  2 ea   bypass select for EX: 0 reg, 1 ex_mem_data, 2 mem_wb_data
//  stall_pc_ifid     out  1      hold PC and IF/ID register
//  bubble_idex       out  1      load NOP into ID/EX
//  isFlush           out  1      flush IF/ID, ID/EX, EX/MEM
//  isCacheStall      out  1      freeze all pipeline registers
//  redirect          out  1      PC takes corrected target (1-cycle pulse)
//  stall_cnt         out  CNT_W  cycles spent in LOADUSE or HOLD
//  flush_cnt         out  CNT_W  number of mispredicts
// BEHAVIOUR
//  - Reset: state RUN; all outputs 0; counters 0; flush counter 0.
//  - States: RUN, LOADUSE, FLUSH, HOLD. Priority per cycle: rst > cache miss > mispredict > load-use.
//  - mispredict = br_valid & (br_taken != br_pred[1]).
//  - HOLD: entered whenever icache_miss|dcache_miss; isCacheStall = 1 combinationally in the
//    same cycle; all registered outputs and the flush counter are frozen. Returns to the saved
//    state on the first cycle with both misses low. A mispredict seen during HOLD is ignored;
//    MEM is frozen, so br_valid is re-presented on exit.
//  - RUN: load-use = ex_memread & ex_regwrite_flag & ex_write_reg != 0 & ((id_uses_rs &
//    id_rs == ex_write_reg) | (id_uses_rt & id_rt == ex_write_reg)). It goes to LOADUSE with
//    stall_pc_ifid = bubble_idex = 1 for exactly 1 cycle, then back to RUN.
//  - Mispredict in RUN/LOADUSE: redirect = 1 for one cycle, then FLUSH. isFlush = 1 for
//    FLUSH_CYCLES cycles starting that cycle; stall/bubble are forced to 0; flush_cnt += 1.
//    A new mispredict inside FLUSH restarts the count and increments flush_cnt again.
//  - Forwarding is registered and updates when ID/EX advances (no HOLD, no stall):
//    forward_a <= 1 if ex_regwrite_flag & ex_write_reg != 0 & ex_write_reg == id_rs;
//    else 2 if the same holds for mem_write_reg; else 0. forward_b is identical using id_rt.
//    EX beats MEM on a tie. Register 0 is never forwarded. On a bubble or flush both are 0.
//  - Counters wrap at 2^CNT_W, never saturate; stall_cnt counts every LOADUSE and HOLD cycle.
//  - Reset mid-FLUSH/HOLD returns to RUN on the next edge with all outputs 0.
// STRUCTURE
//  - Shared package/header: state encodings, FWD_REG=2'd0 / FWD_EXMEM=2'd1 / FWD_MEMWB=2'd2.
//    These are shared with bypath/bypath2 so the select encodings stay consistent.
//  - One sub-module: hazard_fwd_cmp (combinational source/dest compare for one operand),
//    instantiated twice. FSM and counters stay in the top.
// TESTING
//  - EX lw $5, ID add $6,$5,$1 -> bubble_idex=stall_pc_ifid=1 one cycle, next cycle forward_a=2.
//  - EX writes $3, MEM writes $3, ID reads rs=$3 -> forward_a=1 next cycle.
//    Same with $0 -> forward_a=0.
//  - br_valid=1, br_taken=1, br_pred=2'b00 -> redirect pulse, isFlush high 2 cycles, flush_cnt=1.
//  - dcache_miss 5 cycles during FLUSH cycle 1 -> isCacheStall 5 cycles, then 1 flush cycle remains.
//  - Load-use and mispredict in the same cycle -> FLUSH wins, bubble_idex=0, stall_cnt unchanged.
//  - rst asserted in HOLD -> next edge all outputs 0, state RUN, counters 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the EX hazard sequencer and bypass muxes.
// Select codes must match the bypath/bypath2 operand muxes.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LOADUSE,
    ST_FLUSH,
    ST_HOLD
  } state_e;

  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  function automatic logic is_mispredict(
    input logic       v,
    input logic       taken,
    input logic [1:0] pred
  );
    return v & (taken != pred[1]);
  endfunction

endpackage

// File: rtl/hazard_fwd_cmp.sv
// Source/dest compare for one EX operand.
// EX result beats MEM result; $0 never forwards.
module hazard_fwd_cmp
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] ex_write_reg,
  input  logic       ex_regwrite_flag,
  input  logic [4:0] mem_write_reg,
  input  logic       mem_regwrite_flag,
  output logic [1:0] sel
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = ex_regwrite_flag
                 & (ex_write_reg != 5'd0)
                 & (ex_write_reg == src);
  assign mem_hit = mem_regwrite_flag
                 & (mem_write_reg != 5'd0)
                 & (mem_write_reg == src);

  always_comb begin
    sel = FWD_REG;
    if (ex_hit)
      sel = FWD_EXMEM;
    else if (mem_hit)
      sel = FWD_MEMWB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// EX-stage hazard sequencer: bypass selects, load-use bubbles,
// mispredict flushes and cache-miss freeze, plus perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_write_reg,
  input  logic             ex_regwrite_flag,
  input  logic             ex_memread,
  input  logic [4:0]       mem_write_reg,
  input  logic             mem_regwrite_flag,
  input  logic             br_valid,
  input  logic             br_taken,
  input  logic [1:0]       br_pred,
  input  logic             icache_miss,
  input  logic             dcache_miss,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             stall_pc_ifid,
  output logic             bubble_idex,
  output logic             isFlush,
  output logic             isCacheStall,
  output logic             redirect,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] FC_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  state_e           saved_q, saved_d;
  state_e           cur;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [1:0]       fa_q, fa_d, fb_q, fb_d;
  logic [1:0]       fa_cmp, fb_cmp;
  logic             stall_q, stall_d;
  logic             bubble_q, bubble_d;
  logic             flush_q, flush_d;
  logic             redir_q, redir_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             miss, mis, lu;
  logic             take_mis, take_fl, take_lu;

  hazard_fwd_cmp u_cmp_a (
    .src               (id_rs),
    .ex_write_reg      (ex_write_reg),
    .ex_regwrite_flag  (ex_regwrite_flag),
    .mem_write_reg     (mem_write_reg),
    .mem_regwrite_flag (mem_regwrite_flag),
    .sel               (fa_cmp)
  );

  hazard_fwd_cmp u_cmp_b (
    .src               (id_rt),
    .ex_write_reg      (ex_write_reg),
    .ex_regwrite_flag  (ex_regwrite_flag),
    .mem_write_reg     (mem_write_reg),
    .mem_regwrite_flag (mem_regwrite_flag),
    .sel               (fb_cmp)
  );

  assign miss = icache_miss | dcache_miss;
  // On HOLD exit the saved state acts as if it never left.
  assign cur  = (state_q == ST_HOLD) ? saved_q : state_q;
  assign mis  = is_mispredict(br_valid, br_taken, br_pred);
  assign lu   = ex_memread & ex_regwrite_flag
              & (ex_write_reg != 5'd0)
              & ((id_uses_rs & (id_rs == ex_write_reg))
               | (id_uses_rt & (id_rt == ex_write_reg)));

  assign take_mis = mis;
  assign take_fl  = !mis & (cur == ST_FLUSH) & (fcnt_q != 3'd0);
  assign take_lu  = !mis & (cur == ST_RUN) & lu;

  always_comb begin
    state_d     = state_q;
    saved_d     = saved_q;
    fcnt_d      = fcnt_q;
    fa_d        = fa_q;
    fb_d        = fb_q;
    stall_d     = stall_q;
    bubble_d    = bubble_q;
    flush_d     = flush_q;
    redir_d     = redir_q;
    flush_cnt_d = flush_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (state_q == ST_LOADUSE || state_q == ST_HOLD)
      stall_cnt_d = stall_cnt_q + ONE;
    if (miss) begin
      state_d = ST_HOLD;
      saved_d = cur;
    end else begin
      state_d  = ST_RUN;
      saved_d  = ST_RUN;
      fcnt_d   = 3'd0;
      fa_d     = fa_cmp;
      fb_d     = fb_cmp;
      stall_d  = 1'b0;
      bubble_d = 1'b0;
      flush_d  = 1'b0;
      redir_d  = 1'b0;
      unique case (1'b1)
        take_mis: begin
          state_d     = ST_FLUSH;
          fcnt_d      = FC_INIT;
          flush_d     = 1'b1;
          redir_d     = 1'b1;
          flush_cnt_d = flush_cnt_q + ONE;
          fa_d        = FWD_REG;
          fb_d        = FWD_REG;
        end
        take_fl: begin
          state_d = ST_FLUSH;
          fcnt_d  = fcnt_q - 3'd1;
          flush_d = 1'b1;
          fa_d    = FWD_REG;
          fb_d    = FWD_REG;
        end
        take_lu: begin
          state_d  = ST_LOADUSE;
          stall_d  = 1'b1;
          bubble_d = 1'b1;
          fa_d     = FWD_REG;
          fb_d     = FWD_REG;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      saved_q     <= ST_RUN;
      fcnt_q      <= 3'd0;
      fa_q        <= FWD_REG;
      fb_q        <= FWD_REG;
      stall_q     <= 1'b0;
      bubble_q    <= 1'b0;
      flush_q     <= 1'b0;
      redir_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      fcnt_q      <= fcnt_d;
      fa_q        <= fa_d;
      fb_q        <= fb_d;
      stall_q     <= stall_d;
      bubble_q    <= bubble_d;
      flush_q     <= flush_d;
      redir_q     <= redir_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign forward_a     = fa_q;
  assign forward_b     = fb_q;
  assign stall_pc_ifid = stall_q;
  assign bubble_idex   = bubble_q;
  assign isFlush       = flush_q;
  assign redirect      = redir_q;
  assign isCacheStall  = miss & ~rst;
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random
// traffic checked against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_write_reg, mem_write_reg;
  logic        id_uses_rs, id_uses_rt;
  logic        ex_regwrite_flag, ex_memread, mem_regwrite_flag;
  logic        br_valid, br_taken;
  logic [1:0]  br_pred;
  logic        icache_miss, dcache_miss;
  logic [1:0]  forward_a, forward_b;
  logic        stall_pc_ifid, bubble_idex, isFlush;
  logic        isCacheStall, redirect;
  logic [31:0] stall_cnt, flush_cnt;

  int n_run  = 0;
  int n_fail = 0;

  // model state: outputs as seen after the last edge
  logic [1:0]  m_fa, m_fb;
  logic        m_stall, m_flush, m_redir, m_hold;
  int          m_left;
  logic [31:0] m_scnt, m_fcnt;

  hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_write_reg(ex_write_reg),
    .ex_regwrite_flag(ex_regwrite_flag),
    .ex_memread(ex_memread),
    .mem_write_reg(mem_write_reg),
    .mem_regwrite_flag(mem_regwrite_flag),
    .br_valid(br_valid), .br_taken(br_taken), .br_pred(br_pred),
    .icache_miss(icache_miss), .dcache_miss(dcache_miss),
    .forward_a(forward_a), .forward_b(forward_b),
    .stall_pc_ifid(stall_pc_ifid), .bubble_idex(bubble_idex),
    .isFlush(isFlush), .isCacheStall(isCacheStall),
    .redirect(redirect),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] m_src(input logic [4:0] r);
    if (ex_regwrite_flag && ex_write_reg != 0 && ex_write_reg == r)
      return 2'd1;
    if (mem_regwrite_flag && mem_write_reg != 0 && mem_write_reg == r)
      return 2'd2;
    return 2'd0;
  endfunction

  // One clock of the pipeline sequencer, from the rules in words:
  // FLUSH is "isFlush showing", LOADUSE is "bubble showing".
  task automatic model_edge();
    logic mis, lu;
    mis = br_valid && (br_taken != br_pred[1]);
    lu  = ex_memread && ex_regwrite_flag && ex_write_reg != 0 &&
          ((id_uses_rs && id_rs == ex_write_reg) ||
           (id_uses_rt && id_rt == ex_write_reg));
    if (rst) begin
      m_fa = 0; m_fb = 0; m_stall = 0; m_flush = 0; m_redir = 0;
      m_hold = 0; m_left = 0; m_scnt = 0; m_fcnt = 0;
    end else begin
      if (m_hold || m_stall) m_scnt = m_scnt + 1;
      if (icache_miss || dcache_miss) begin
        m_hold = 1;
      end else begin
        m_hold  = 0;
        m_redir = 0;
        if (mis) begin
          m_redir = 1; m_flush = 1; m_left = FC - 1;
          m_fcnt = m_fcnt + 1; m_stall = 0; m_fa = 0; m_fb = 0;
        end else if (m_flush && m_left > 0) begin
          m_left = m_left - 1; m_fa = 0; m_fb = 0;
        end else if (!m_flush && !m_stall && lu) begin
          m_stall = 1; m_fa = 0; m_fb = 0;
        end else begin
          m_flush = 0; m_stall = 0;
          m_fa = m_src(id_rs); m_fb = m_src(id_rt);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_write_reg = 0; ex_regwrite_flag = 0; ex_memread = 0;
    mem_write_reg = 0; mem_regwrite_flag = 0;
    br_valid = 0; br_taken = 0; br_pred = 0;
    icache_miss = 0; dcache_miss = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    step(); step();
    n_run++;
    if ({forward_a, forward_b, stall_pc_ifid, bubble_idex,
         isFlush, redirect} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outs got=%h exp=00",
        {forward_a, forward_b, stall_pc_ifid, bubble_idex, isFlush, redirect});
    end
    n_run++;
    if (stall_cnt !== 0 || flush_cnt !== 0) begin
      n_fail++;
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
    end
    rst = 0; step();
  endtask

  task automatic test_loaduse();
    logic [31:0] sc0;
    idle(); step();
    sc0 = stall_cnt;
    ex_write_reg = 5; ex_regwrite_flag = 1; ex_memread = 1;
    id_rs = 5; id_uses_rs = 1; id_rt = 1; id_uses_rt = 1;
    step();
    n_run++;
    if (bubble_idex !== 1 || stall_pc_ifid !== 1 || forward_a !== 0) begin
      n_fail++;
      $display("FAIL lu_bubble got=%b%b fa=%0d exp=11 fa=0",
        bubble_idex, stall_pc_ifid, forward_a);
    end
    ex_write_reg = 0; ex_regwrite_flag = 0; ex_memread = 0;
    mem_write_reg = 5; mem_regwrite_flag = 1;
    step();
    n_run++;
    if (bubble_idex !== 0 || stall_pc_ifid !== 0 ||
        forward_a !== 2 || forward_b !== 0) begin
      n_fail++;
      $display("FAIL lu_after got=%b%b fa=%0d fb=%0d exp=00 fa=2 fb=0",
        bubble_idex, stall_pc_ifid, forward_a, forward_b);
    end
    n_run++;
    if (stall_cnt !== sc0 + 1) begin
      n_fail++;
      $display("FAIL lu_cnt got=%0d exp=%0d", stall_cnt, sc0 + 1);
    end
  endtask

  task automatic test_forward();
    idle();
    ex_write_reg = 3; ex_regwrite_flag = 1;
    mem_write_reg = 3; mem_regwrite_flag = 1; id_rs = 3;
    step();
    n_run++;
    if (forward_a !== 1) begin
      n_fail++;
      $display("FAIL fwd_tie got=%0d exp=1", forward_a);
    end
    ex_write_reg = 0; mem_write_reg = 0; id_rs = 0;
    step();
    n_run++;
    if (forward_a !== 0) begin
      n_fail++;
      $display("FAIL fwd_r0 got=%0d exp=0", forward_a);
    end
    ex_write_reg = 7; mem_write_reg = 9; id_rt = 9; id_rs = 7;
    step();
    n_run++;
    if (forward_b !== 2 || forward_a !== 1) begin
      n_fail++;
      $display("FAIL fwd_ab got=%0d/%0d exp=1/2", forward_a, forward_b);
    end
  endtask

  task automatic test_mispredict();
    logic [31:0] fc0;
    idle(); step();
    fc0 = flush_cnt;
    br_valid = 1; br_taken = 1; br_pred = 2'b00;
    step();
    n_run++;
    if (redirect !== 1 || isFlush !== 1 || flush_cnt !== fc0 + 1) begin
      n_fail++;
      $display("FAIL mis_first got=%b%b cnt=%0d exp=11 cnt=%0d",
        redirect, isFlush, flush_cnt, fc0 + 1);
    end
    br_valid = 0;
    step();
    n_run++;
    if (redirect !== 0 || isFlush !== 1) begin
      n_fail++;
      $display("FAIL mis_second got=%b%b exp=01", redirect, isFlush);
    end
    step();
    n_run++;
    if (isFlush !== 0) begin
      n_fail++;
      $display("FAIL mis_end got=%b exp=0", isFlush);
    end
  endtask

  task automatic test_hold_in_flush();
    logic [31:0] sc0;
    idle(); step();
    br_valid = 1; br_taken = 0; br_pred = 2'b10;
    step();
    br_valid = 0;
    sc0 = stall_cnt;
    dcache_miss = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_run++;
      if (isCacheStall !== 1) begin
        n_fail++;
        $display("FAIL hold_cs cyc=%0d got=%b exp=1", i, isCacheStall);
      end
      step();
      n_run++;
      if (isFlush !== 1) begin
        n_fail++;
        $display("FAIL hold_frozen cyc=%0d got=%b exp=1", i, isFlush);
      end
    end
    dcache_miss = 0;
    step();
    n_run++;
    if (isFlush !== 1 || stall_cnt !== sc0 + 5) begin
      n_fail++;
      $display("FAIL hold_exit got=%b cnt=%0d exp=1 cnt=%0d",
        isFlush, stall_cnt, sc0 + 5);
    end
    step();
    n_run++;
    if (isFlush !== 0) begin
      n_fail++;
      $display("FAIL hold_done got=%b exp=0", isFlush);
    end
  endtask

  task automatic test_lu_vs_mis();
    logic [31:0] sc0;
    idle(); step(); step(); step();
    sc0 = stall_cnt;
    ex_write_reg = 4; ex_regwrite_flag = 1; ex_memread = 1;
    id_rs = 4; id_uses_rs = 1;
    br_valid = 1; br_taken = 1; br_pred = 2'b01;
    step();
    n_run++;
    if (bubble_idex !== 0 || stall_pc_ifid !== 0 || isFlush !== 1) begin
      n_fail++;
      $display("FAIL luvm_out got=%b%b%b exp=001",
        bubble_idex, stall_pc_ifid, isFlush);
    end
    idle(); step();
    n_run++;
    if (stall_cnt !== sc0) begin
      n_fail++;
      $display("FAIL luvm_cnt got=%0d exp=%0d", stall_cnt, sc0);
    end
  endtask

  task automatic test_rst_in_hold();
    idle(); step();
    br_valid = 1; br_taken = 1; br_pred = 0;
    step();
    br_valid = 0; icache_miss = 1;
    step(); step();
    rst = 1;
    step();
    n_run++;
    if ({forward_a, forward_b, stall_pc_ifid, bubble_idex, isFlush,
         redirect} !== 8'h00 || stall_cnt !== 0 || flush_cnt !== 0) begin
      n_fail++;
      $display("FAIL rst_hold outs=%h cnt=%0d/%0d exp=00 0/0",
        {forward_a, forward_b, stall_pc_ifid, bubble_idex, isFlush, redirect},
        stall_cnt, flush_cnt);
    end
    idle();
    ex_write_reg = 6; ex_regwrite_flag = 1; ex_memread = 1;
    id_rt = 6; id_uses_rt = 1;
    step();
    n_run++;
    if (bubble_idex !== 1) begin
      n_fail++;
      $display("FAIL rst_run got=%b exp=1", bubble_idex);
    end
  endtask

  task automatic test_random();
    logic [7:0] got, exp;
    for (int i = 0; i < 600; i++) begin
      rst               = ($urandom_range(0, 99) < 2);
      id_rs             = 5'($urandom_range(0, 3));
      id_rt             = 5'($urandom_range(0, 3));
      id_uses_rs        = 1'($urandom);
      id_uses_rt        = 1'($urandom);
      ex_write_reg      = 5'($urandom_range(0, 3));
      ex_regwrite_flag  = 1'($urandom);
      ex_memread        = 1'($urandom);
      mem_write_reg     = 5'($urandom_range(0, 3));
      mem_regwrite_flag = 1'($urandom);
      br_valid          = ($urandom_range(0, 99) < 15);
      br_taken          = 1'($urandom);
      br_pred           = 2'($urandom);
      icache_miss       = ($urandom_range(0, 99) < 6);
      dcache_miss       = ($urandom_range(0, 99) < 6);
      #1;
      n_run++;
      if (isCacheStall !== ((icache_miss | dcache_miss) & ~rst)) begin
        n_fail++;
        $display("FAIL rnd_cs cyc=%0d got=%b", i, isCacheStall);
      end
      step();
      got = {forward_a, forward_b, stall_pc_ifid, bubble_idex,
             isFlush, redirect};
      exp = {m_fa, m_fb, m_stall, m_stall, m_flush, m_redir};
      n_run++;
      if (got !== exp || stall_cnt !== m_scnt || flush_cnt !== m_fcnt) begin
        n_fail++;
        $display("FAIL rnd cyc=%0d got=%h %0d/%0d exp=%h %0d/%0d",
          i, got, stall_cnt, flush_cnt, exp, m_scnt, m_fcnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_loaduse();
    test_forward();
    test_mispredict();
    test_hold_in_flush();
    test_lu_vs_mis();
    test_rst_in_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
